// File: rtl/urp_pcie_tx_tlp_engine.sv
// urp_pcie_tx_tlp_engine: packs requests into TLPs, queues them DW-serially
// per virtual channel, reassembles and round-robin arbitrates onto one port.
module urp_pcie_tx_tlp_engine #(
    parameter int N_VC           = 2,
    parameter int PAYLOAD_DW     = 4,
    parameter int FIFO_DEPTH_LG2 = 4,
    localparam int TLP_DW        = 3 + PAYLOAD_DW,
    localparam int TLP_W         = 32 * TLP_DW,
    localparam int VC_W          = (N_VC > 1) ? $clog2(N_VC) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [32*PAYLOAD_DW-1:0] payload_i,
    input  logic [31:0]             addr_i,
    input  logic [2:0]              header_fmt_i,
    input  logic [4:0]              header_type_i,
    input  logic [2:0]              header_tc_i,
    input  logic [9:0]              header_length_i,
    input  logic [15:0]             header_requestID_i,
    input  logic [15:0]             header_completID_i,
    output logic [TLP_W-1:0]        tlp_o,
    output logic [VC_W-1:0]         tlp_vc_o,
    output logic                    tlp_valid_o,
    input  logic                    tlp_ready_i,
    output logic                    err_unsupported_o
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_LG2;
    localparam int CNT_W = FIFO_DEPTH_LG2 + 1;
    localparam int IDX_W = $clog2(TLP_DW);

    typedef enum logic {S_IDLE, S_SEND} ser_state_t;

    ser_state_t ser_state, ser_next;

    logic                      rdy_q;
    logic [TLP_W-1:0]          ser_tlp;
    logic [IDX_W-1:0]          ser_idx;
    logic [VC_W-1:0]           ser_vc;
    logic                      fifo_wr;
    logic [31:0]               wdata;

    logic [VC_W-1:0]           req_vc;
    logic                      type_mem;
    logic                      type_cpl;
    logic                      type_ok;
    logic [31:0]               dw0;
    logic [TLP_W-1:0]          req_tlp;
    logic                      accept;

    logic [31:0]               fifo_mem [N_VC][DEPTH];
    logic [FIFO_DEPTH_LG2-1:0] wptr [N_VC];
    logic [FIFO_DEPTH_LG2-1:0] rptr [N_VC];
    logic [CNT_W-1:0]          cnt  [N_VC];
    logic [N_VC-1:0]           wr_en;
    logic [N_VC-1:0]           pop;

    logic [TLP_W-1:0]          asm_q   [N_VC];
    logic [IDX_W-1:0]          asm_cnt [N_VC];
    logic [N_VC-1:0]           pending;

    logic [VC_W-1:0]           rr_ptr;
    logic [VC_W-1:0]           gnt_vc;
    logic [VC_W-1:0]           scan_vc;
    logic                      gnt_found;
    logic                      load;

    assign req_vc   = VC_W'({1'b0, header_tc_i} % 4'(N_VC));
    assign type_mem = (header_type_i[4:1] == 4'b0000);
    assign type_cpl = (header_type_i[4:1] == 4'b0101);
    assign type_ok  = type_mem | type_cpl;
    assign dw0      = {header_fmt_i, header_type_i, header_tc_i,
                       header_length_i, 11'b0};
    assign req_tlp  = type_cpl
        ? {dw0, header_requestID_i, header_completID_i, addr_i, payload_i}
        : {dw0, header_requestID_i, addr_i, 16'h0, payload_i};

    // whole-TLP space check: a request only starts when the full TLP fits
    assign req_ready_o = rdy_q && (ser_state == S_IDLE) &&
                         (cnt[req_vc] <= CNT_W'(DEPTH - TLP_DW));
    assign accept      = req_valid_i && req_ready_o;
    assign wdata       = ser_tlp[TLP_W-1 -: 32];

    // serializer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ser_state <= S_IDLE;
        else        ser_state <= ser_next;
    end

    // serializer next state: one SEND pass of TLP_DW cycles per legal request
    always_comb begin
        ser_next = ser_state;
        case (ser_state)
            S_IDLE:  if (accept && type_ok) ser_next = S_SEND;
            S_SEND:  if (ser_idx == IDX_W'(TLP_DW - 1)) ser_next = S_IDLE;
            default: ser_next = S_IDLE;
        endcase
    end

    // serializer outputs: one DW written per SEND cycle
    always_comb begin
        fifo_wr = (ser_state == S_SEND);
        wr_en   = '0;
        for (int v = 0; v < N_VC; v++)
            wr_en[v] = fifo_wr && (ser_vc == VC_W'(v));
    end

    // serializer datapath, ready gating after reset and illegal-type pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q             <= 1'b0;
            err_unsupported_o <= 1'b0;
            ser_tlp           <= '0;
            ser_idx           <= '0;
            ser_vc            <= '0;
        end else begin
            rdy_q             <= 1'b1;
            err_unsupported_o <= accept && !type_ok;
            if (accept && type_ok) begin
                ser_tlp <= req_tlp;
                ser_vc  <= req_vc;
                ser_idx <= '0;
            end else if (fifo_wr) begin
                ser_tlp <= {ser_tlp[TLP_W-33:0], 32'h0};
                ser_idx <= ser_idx + 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy guards reads
    always_ff @(posedge clk) begin
        for (int v = 0; v < N_VC; v++)
            if (wr_en[v]) fifo_mem[v][wptr[v]] <= wdata;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < N_VC; v++) begin
                wptr[v] <= '0;
                rptr[v] <= '0;
                cnt[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < N_VC; v++) begin
                if (wr_en[v]) wptr[v] <= wptr[v] + 1'b1;
                if (pop[v])   rptr[v] <= rptr[v] + 1'b1;
                case ({wr_en[v], pop[v]})
                    2'b10:   cnt[v] <= cnt[v] + 1'b1;
                    2'b01:   cnt[v] <= cnt[v] - 1'b1;
                    default: cnt[v] <= cnt[v];
                endcase
            end
        end
    end

    // assembler FILL pops whenever data is present and no TLP is held
    always_comb begin
        pop = '0;
        for (int v = 0; v < N_VC; v++)
            pop[v] = !pending[v] && (cnt[v] != '0);
    end

    // assembler shift registers; pending marks a complete TLP in HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            for (int v = 0; v < N_VC; v++) begin
                asm_q[v]   <= '0;
                asm_cnt[v] <= '0;
            end
        end else begin
            for (int v = 0; v < N_VC; v++) begin
                if (pop[v]) begin
                    asm_q[v] <= {asm_q[v][TLP_W-33:0], fifo_mem[v][rptr[v]]};
                    if (asm_cnt[v] == IDX_W'(TLP_DW - 1)) begin
                        asm_cnt[v] <= '0;
                        pending[v] <= 1'b1;
                    end else begin
                        asm_cnt[v] <= asm_cnt[v] + 1'b1;
                    end
                end else if (load && (gnt_vc == VC_W'(v))) begin
                    pending[v] <= 1'b0;
                end
            end
        end
    end

    // round-robin grant: first pending VC at or after the pointer
    always_comb begin
        gnt_found = 1'b0;
        gnt_vc    = rr_ptr;
        scan_vc   = rr_ptr;
        for (int i = 0; i < N_VC; i++) begin
            scan_vc = VC_W'((int'(rr_ptr) + i) % N_VC);
            if (!gnt_found && pending[scan_vc]) begin
                gnt_found = 1'b1;
                gnt_vc    = scan_vc;
            end
        end
    end

    assign load = gnt_found && (!tlp_valid_o || tlp_ready_i);

    // output register; holds while stalled, reloads back-to-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlp_o       <= '0;
            tlp_vc_o    <= '0;
            tlp_valid_o <= 1'b0;
            rr_ptr      <= '0;
        end else if (load) begin
            tlp_o       <= asm_q[gnt_vc];
            tlp_vc_o    <= gnt_vc;
            tlp_valid_o <= 1'b1;
            rr_ptr      <= VC_W'((int'(gnt_vc) + 1) % N_VC);
        end else if (tlp_ready_i) begin
            tlp_valid_o <= 1'b0;
        end
    end

endmodule
